branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Branch/jump redirect controller for the ID stage of the pipelined MIPS core. Evaluates BEQ, BNE, J, JAL and JR in ID, computes the redirect target, and sequences the PC mux select and IF/ID flush. When a branch operand is still being produced by an in-flight load, it stalls the front end until the operand is ready. It sits between the ID-stage decode/forwarding logic and the PC register / IF/ID pipeline register.

## Interface
Parameters:
- NBITS, 32, datapath width; fixed at 32 for the MIPS PC.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  valid instruction in ID
- id_is_branch  in  1  BEQ or BNE in ID
- id_is_bne  in  1  qualifies id_is_branch: 1 = BNE, 0 = BEQ
- id_is_jump  in  1  J or JAL in ID
- id_is_jr  in  1  JR in ID
- pc_plus4  in  32  PC+4 of the ID instruction
- imm_sext  in  32  sign-extended 16-bit immediate
- jump_index  in  26  instr[25:0]
- rs_data, rt_data  in  32  forwarded operands
- operand_ready  in  1  rs/rt forwarding valid this cycle (0 while a load producing rs/rt is in EX/MEM)
- stall  out  1  combinational; hold PC and IF/ID
- redirect  out  1  registered one-cycle pulse; PC loads target_pc
- target_pc  out  32  registered redirect target
- flush_ifid  out  1  registered one-cycle pulse; zero IF/ID

## Operation
- Op select priority when several op inputs are high: jr > jump > branch. Ops are ignored when id_valid=0.
- Operand need: branch needs rs and rt; JR needs rs; J/JAL need none and ignore operand_ready.
- Targets (mod 2^32, carry discarded):
  - branch: pc_plus4 + {imm_sext[29:0],2'b00}
  - jump: {pc_plus4[31:28], jump_index, 2'b00}
  - JR: rs_data
- Taken: BEQ when rs_data==rt_data; BNE when they differ; jumps always taken.
- FSM states: IDLE, WAIT_OPS, REDIRECT.
  - IDLE, op present, operands needed and operand_ready=0: go to WAIT_OPS; stall=1.
  - IDLE or WAIT_OPS, op present and operands ready (or not needed): evaluate.
    - Taken: register target_pc, assert redirect (and flush_ifid per config) next cycle, go to REDIRECT.
    - Not taken: stay/return to IDLE; no redirect, no flush.
  - WAIT_OPS: stall=1 while operand_ready=0.
  - WAIT_OPS, id_valid drops (external flush): go to IDLE, stall=0, nothing issued.
  - REDIRECT: redirect pulse visible; ID contents are not evaluated (delay-slot or flushed instruction). Go to IDLE next cycle.
- stall = id_valid & op_needs_operands & ~operand_ready & (state != REDIRECT).
- Reset: state=IDLE; redirect=0, flush_ifid=0, target_pc=32'h0, stall=0 (id_valid is expected low during reset).

## Timing
- Decision in cycle T (ops ready) -> redirect, target_pc and flush_ifid valid in T+1 for exactly one cycle. The PC captures the target at the end of T+1.
- Load-use on a branch: stall is high from the first cycle the op is seen until the cycle operand_ready=1. The decision happens in that ready cycle, so total penalty is N stall cycles + 1.
- Not-taken branch: zero extra cycles.
- Back-to-back redirects: minimum spacing of 2 cycles (REDIRECT always returns to IDLE).
- target_pc holds its last value between redirects.
- Asynchronous reset asserted mid-WAIT_OPS or mid-REDIRECT clears all outputs immediately, with no pulse afterward.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: MIPS delay-slot semantics. flush_ifid is never asserted, and the instruction after the control op executes.
- Undefined: flush_ifid pulses together with redirect on every taken branch/jump, squashing the sequential instruction.

## Test plan
- BEQ, rs=rt=5, pc_plus4=0x0000_0100, imm_sext=0xFFFF_FFFC -> one cycle later redirect=1, target_pc=0x0000_00F0; flush_ifid=1 only without BRANCH_DELAY_SLOT_EN.
- BNE, rs=rt=7 -> no redirect, no flush, stall=0 throughout.
- J, pc_plus4=0xA000_0004, jump_index=0x0000_040 -> target_pc=0xA000_0100; operand_ready=0 is ignored and stall stays 0.
- JR with operand_ready=0 for 2 cycles, rs=0x0040_0020 -> stall high 2 cycles, then redirect with target 0x0040_0020 in the cycle after ready.
- Branch in WAIT_OPS, then id_valid drops -> stall drops the same cycle, FSM returns to IDLE, no redirect.
- Reset asserted during REDIRECT -> redirect, flush_ifid and target_pc go to 0 immediately, and no pulse follows reset release.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// ID-stage branch/jump redirect controller for the pipelined MIPS core.
// Evaluates BEQ/BNE/J/JAL/JR, registers the redirect target and pulses
// redirect (and flush_ifid) one cycle after a taken decision. The front end
// is stalled while a needed operand is still being produced by a load.
// Build option: define BRANCH_DELAY_SLOT_EN for delay-slot semantics
// (flush_ifid never asserted).
module branch_redirect_ctrl #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_is_bne,
    input  logic             id_is_jump,
    input  logic             id_is_jr,
    input  logic [NBITS-1:0] pc_plus4,
    input  logic [NBITS-1:0] imm_sext,
    input  logic [25:0]      jump_index,
    input  logic [NBITS-1:0] rs_data,
    input  logic [NBITS-1:0] rt_data,
    input  logic             operand_ready,
    output logic             stall,
    output logic             redirect,
    output logic [NBITS-1:0] target_pc,
    output logic             flush_ifid
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic FLUSH_ON_TAKEN = 1'b0;
`else
    localparam logic FLUSH_ON_TAKEN = 1'b1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OPS,
        REDIRECT
    } state_t;

    state_t           r_state;
    logic             r_redirect;
    logic             r_flush;
    logic [NBITS-1:0] r_target;

    logic             w_op_jr;
    logic             w_op_jump;
    logic             w_op_br;
    logic             w_op_any;
    logic             w_needs_ops;
    logic             w_ops_ok;
    logic             w_taken;
    logic [NBITS-1:0] w_target;

    // Op decode with priority jr > jump > branch; nothing counts without id_valid
    always_comb begin
        w_op_jr     = id_valid & id_is_jr;
        w_op_jump   = id_valid & ~id_is_jr & id_is_jump;
        w_op_br     = id_valid & ~id_is_jr & ~id_is_jump & id_is_branch;
        w_op_any    = w_op_jr | w_op_jump | w_op_br;
        w_needs_ops = w_op_jr | w_op_br;
        w_ops_ok    = ~w_needs_ops | operand_ready;
    end

    // Redirect target and taken decision for the selected op
    always_comb begin
        w_target = pc_plus4 + (imm_sext << 2);
        w_taken  = 1'b0;
        if (w_op_jr) begin
            w_target = rs_data;
            w_taken  = 1'b1;
        end else if (w_op_jump) begin
            w_target = {pc_plus4[NBITS-1:NBITS-4], jump_index, 2'b00};
            w_taken  = 1'b1;
        end else if (w_op_br) begin
            w_taken = id_is_bne ? (rs_data != rt_data) : (rs_data == rt_data);
        end
    end

    // Stall is suppressed in REDIRECT: the ID slot then holds a delay-slot or squashed instruction
    assign stall = w_needs_ops & ~operand_ready & (r_state != REDIRECT);

    // Redirect sequencer with registered pulse outputs and held target
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_redirect <= 1'b0;
            r_flush    <= 1'b0;
            r_target   <= '0;
        end else begin
            r_redirect <= 1'b0;
            r_flush    <= 1'b0;
            unique case (r_state)
                IDLE, WAIT_OPS: begin
                    if (w_op_any && w_ops_ok) begin
                        if (w_taken) begin
                            r_target   <= w_target;
                            r_redirect <= 1'b1;
                            r_flush    <= FLUSH_ON_TAKEN;
                            r_state    <= REDIRECT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_op_any) begin
                        r_state <= WAIT_OPS;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REDIRECT: r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
        end
    end

    assign redirect   = r_redirect;
    assign flush_ifid = r_flush;
    assign target_pc  = r_target;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Testbench for branch_redirect_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_branch_redirect_ctrl;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic FL = 1'b0;
`else
    localparam logic FL = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_is_branch, id_is_bne, id_is_jump, id_is_jr;
    logic [31:0] pc_plus4, imm_sext, rs_data, rt_data;
    logic [25:0] jump_index;
    logic        operand_ready;
    logic        stall, redirect, flush_ifid;
    logic [31:0] target_pc;

    int checks = 0;
    int errors = 0;

    // behavioural model state: what the registered outputs should show now
    logic        m_redir, m_flush;
    logic [31:0] m_tgt;

    branch_redirect_ctrl #(.NBITS(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_is_bne(id_is_bne), .id_is_jump(id_is_jump), .id_is_jr(id_is_jr),
        .pc_plus4(pc_plus4), .imm_sext(imm_sext), .jump_index(jump_index),
        .rs_data(rs_data), .rt_data(rt_data), .operand_ready(operand_ready),
        .stall(stall), .redirect(redirect), .target_pc(target_pc), .flush_ifid(flush_ifid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, jr, j, br, bne, rdy;
        logic [31:0] pc4, imm, rs, rt;
        logic [25:0] idx;
        logic        e_stall, e_redir;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, jr, j, br, bne, rdy,
                                input logic [31:0] pc4, imm, rs, rt, input logic [25:0] idx,
                                input logic e_stall, e_redir, input logic [31:0] e_tgt);
        vec_t t;
        t.v = v; t.jr = jr; t.j = j; t.br = br; t.bne = bne; t.rdy = rdy;
        t.pc4 = pc4; t.imm = imm; t.rs = rs; t.rt = rt; t.idx = idx;
        t.e_stall = e_stall; t.e_redir = e_redir; t.e_tgt = e_tgt;
        return t;
    endfunction

    task automatic drive(input logic v, jr, j, br, bne, rdy,
                         input logic [31:0] pc4, imm, rs, rt, input logic [25:0] idx);
        id_valid = v; id_is_jr = jr; id_is_jump = j; id_is_branch = br; id_is_bne = bne;
        operand_ready = rdy; pc_plus4 = pc4; imm_sext = imm; rs_data = rs; rt_data = rt;
        jump_index = idx;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 26'h0);
    endtask

    // Inputs are applied 1 time unit after a rising edge; stall is sampled
    // mid-cycle, registered outputs 1 unit after the next rising edge.
    task automatic mid();
        #4;
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    // Reference model step: expected stall for the current inputs, and the
    // registered outputs that should appear after the next edge.
    task automatic model_step(output logic e_stall);
        logic busy, op_jr, op_j, op_b, needs, taken;
        logic [31:0] t;
        busy  = m_redir;
        op_jr = id_valid && id_is_jr;
        op_j  = id_valid && !id_is_jr && id_is_jump;
        op_b  = id_valid && !id_is_jr && !id_is_jump && id_is_branch;
        needs = op_jr || op_b;
        e_stall = !busy && needs && !operand_ready;
        m_redir = 1'b0;
        m_flush = 1'b0;
        if (!busy && (op_jr || op_j || op_b) && (!needs || operand_ready)) begin
            if (op_b) taken = id_is_bne ? (rs_data != rt_data) : (rs_data == rt_data);
            else      taken = 1'b1;
            if (op_jr)     t = rs_data;
            else if (op_j) t = (pc_plus4 & 32'hF000_0000) | (32'(jump_index) * 4);
            else           t = pc_plus4 + imm_sext * 4;
            if (taken) begin
                m_redir = 1'b1;
                m_flush = FL;
                m_tgt   = t;
            end
        end
    endtask

    initial begin
        logic e_st;
        logic [31:0] x;

        // ---- directed vector table (each applied from IDLE, followed by an idle cycle)
        //         v  jr j  br bne rdy pc4           imm           rs            rt            idx          stall redir tgt
        tv[0]  = mk(1, 0, 0, 1, 0, 1, 32'h0000_0100, 32'hFFFF_FFFC, 32'd5,        32'd5,        26'h0,       0, 1, 32'h0000_00F0);
        tv[1]  = mk(1, 0, 0, 1, 1, 1, 32'h0000_0100, 32'h0000_0010, 32'd7,        32'd7,        26'h0,       0, 0, 32'h0);
        tv[2]  = mk(1, 0, 1, 0, 0, 0, 32'hA000_0004, 32'h0,         32'h0,        32'h0,        26'h0000040, 0, 1, 32'hA000_0100);
        tv[3]  = mk(1, 1, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0040_0020,32'h0,        26'h0,       0, 1, 32'h0040_0020);
        tv[4]  = mk(1, 0, 0, 1, 0, 1, 32'h0000_0100, 32'h0000_0004, 32'd1,        32'd2,        26'h0,       0, 0, 32'h0);
        tv[5]  = mk(1, 0, 0, 1, 1, 1, 32'h0000_1000, 32'h0000_0010, 32'd1,        32'd2,        26'h0,       0, 1, 32'h0000_1040);
        tv[6]  = mk(1, 1, 1, 1, 0, 1, 32'h0000_1000, 32'h0000_0010, 32'h1234_5678,32'h0,        26'h0000123, 0, 1, 32'h1234_5678);
        tv[7]  = mk(1, 0, 1, 1, 0, 1, 32'h3000_0000, 32'h0000_0010, 32'd1,        32'd2,        26'h3FF_FFFF,0, 1, 32'h3FFF_FFFC);
        tv[8]  = mk(0, 1, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_0444,32'h0,        26'h0,       0, 0, 32'h0);
        tv[9]  = mk(1, 0, 0, 1, 0, 0, 32'h0000_0100, 32'h0000_0004, 32'd3,        32'd3,        26'h0,       1, 0, 32'h0);
        tv[10] = mk(1, 0, 0, 1, 0, 1, 32'hFFFF_FFF0, 32'h0000_0010, 32'd9,        32'd9,        26'h0,       0, 1, 32'h0000_0030);
        tv[11] = mk(1, 1, 1, 0, 0, 0, 32'h0000_0100, 32'h0,         32'h0000_0888,32'h0,        26'h0000001, 1, 0, 32'h0);

        // ---- reset state
        reset = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_redirect", redirect, 0);
        chk("reset_flush", flush_ifid, 0);
        chk("reset_target", target_pc, 32'h0);
        chk("reset_stall", stall, 0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tv[i].v, tv[i].jr, tv[i].j, tv[i].br, tv[i].bne, tv[i].rdy,
                  tv[i].pc4, tv[i].imm, tv[i].rs, tv[i].rt, tv[i].idx);
            mid();
            chk($sformatf("vec%0d_stall", i), stall, tv[i].e_stall);
            edge_();
            chk($sformatf("vec%0d_redirect", i), redirect, tv[i].e_redir);
            chk($sformatf("vec%0d_flush", i), flush_ifid, tv[i].e_redir & FL);
            if (tv[i].e_redir) chk($sformatf("vec%0d_target", i), target_pc, tv[i].e_tgt);
            idle_in();
            edge_();
            chk($sformatf("vec%0d_pulse_end", i), redirect, 0);
        end

        // ---- JR load-use: two stall cycles, decision in the ready cycle
        drive(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0040_0020, 32'h0, 26'h0);
        for (int c = 0; c < 2; c++) begin
            mid();
            chk($sformatf("jr_wait%0d_stall", c), stall, 1);
            edge_();
            chk($sformatf("jr_wait%0d_redirect", c), redirect, 0);
        end
        operand_ready = 1'b1;
        mid();
        chk("jr_ready_stall", stall, 0);
        edge_();
        chk("jr_redirect", redirect, 1);
        chk("jr_target", target_pc, 32'h0040_0020);
        chk("jr_flush", flush_ifid, FL);
        idle_in();
        edge_();
        chk("jr_pulse_end", redirect, 0);
        chk("jr_flush_end", flush_ifid, 0);
        chk("jr_target_hold", target_pc, 32'h0040_0020);

        // ---- branch waiting, then id_valid drops (external flush)
        drive(1, 0, 0, 1, 0, 0, 32'h0000_0200, 32'h1, 32'd1, 32'd1, 26'h0);
        mid();
        chk("drop_wait_stall", stall, 1);
        edge_();
        id_valid = 1'b0;
        #1;
        chk("drop_stall_same_cycle", stall, 0);
        #3;
        edge_();
        chk("drop_no_redirect", redirect, 0);
        drive(1, 0, 0, 1, 0, 1, 32'h0000_0200, 32'h1, 32'd1, 32'd1, 26'h0);
        edge_();
        chk("drop_then_taken_redirect", redirect, 1);
        chk("drop_then_taken_target", target_pc, 32'h0000_0204);
        idle_in();
        edge_();

        // ---- back-to-back: ID ignored during REDIRECT (no stall), then evaluated again
        drive(1, 0, 1, 0, 0, 0, 32'h0000_0004, 32'h0, 32'h0, 32'h0, 26'h0000100);
        edge_();
        chk("b2b_first_redirect", redirect, 1);
        chk("b2b_first_target", target_pc, 32'h0000_0400);
        drive(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0999, 32'h0, 26'h0);
        mid();
        chk("b2b_redirect_state_stall", stall, 0);
        edge_();
        chk("b2b_gap_redirect", redirect, 0);
        chk("b2b_gap_target_hold", target_pc, 32'h0000_0400);
        mid();
        chk("b2b_idle_stall", stall, 1);
        edge_();
        operand_ready = 1'b1;
        edge_();
        chk("b2b_second_redirect", redirect, 1);
        chk("b2b_second_target", target_pc, 32'h0000_0999);
        idle_in();
        edge_();

        // ---- asynchronous reset during REDIRECT
        drive(1, 0, 1, 0, 0, 0, 32'hA000_0004, 32'h0, 32'h0, 32'h0, 26'h0000040);
        edge_();
        chk("rst_pre_redirect", redirect, 1);
        idle_in();
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_redirect", redirect, 0);
        chk("rst_async_flush", flush_ifid, 0);
        chk("rst_async_target", target_pc, 32'h0);
        edge_();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            edge_();
            chk($sformatf("rst_post%0d_redirect", c), redirect, 0);
            chk($sformatf("rst_post%0d_flush", c), flush_ifid, 0);
        end

        // ---- randomized stimulus against the reference model
        reset = 1'b1;
        edge_();
        reset = 1'b0;
        m_redir = 1'b0;
        m_flush = 1'b0;
        m_tgt   = 32'h0;
        for (int n = 0; n < 1500; n++) begin
            x = $urandom;
            id_valid      = ($urandom_range(3, 0) != 0);
            id_is_jr      = ($urandom_range(4, 0) == 0);
            id_is_jump    = ($urandom_range(3, 0) == 0);
            id_is_branch  = ($urandom_range(1, 0) == 1);
            id_is_bne     = x[20];
            operand_ready = ($urandom_range(4, 0) < 3);
            pc_plus4      = $urandom & 32'hFFFF_FFFC;
            imm_sext      = {{16{x[15]}}, x[15:0]};
            rs_data       = $urandom_range(7, 0);
            rt_data       = x[21] ? rs_data : 32'($urandom_range(7, 0));
            if (x[22]) rs_data = $urandom;
            jump_index    = 26'($urandom);
            model_step(e_st);
            mid();
            chk($sformatf("rnd%0d_stall", n), stall, e_st);
            edge_();
            chk($sformatf("rnd%0d_redirect", n), redirect, m_redir);
            chk($sformatf("rnd%0d_flush", n), flush_ifid, m_flush);
            chk($sformatf("rnd%0d_target", n), target_pc, m_tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
